// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg: shared op codes, FSM encoding and width defaults for the execute-stage ALU
package alu_ops_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int SHAMT_WIDTH_DEF = 5;
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_NOR = 4'b0010,
        OP_ADD = 4'b0011,
        OP_SUB = 4'b0100,
        OP_LUI = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111
    } alu_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;
endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle logical shifter with down-counter
// Ports: clk/reset; load captures load_data/load_cnt/dir_right and performs the first step;
// en performs one further step; data_next is the value after the current step; done flags the step that empties the counter
module alu_serial_shifter
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   dir_right,
    input  logic                   en,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic [SHAMT_WIDTH-1:0] load_cnt,
    output logic [DATA_WIDTH-1:0]  data_next,
    output logic                   done
);
    logic [DATA_WIDTH-1:0] data, src;
    logic [SHAMT_WIDTH-1:0] cnt, cnt_src;
    logic right, step_right;
    // the load edge already performs the first shift, so a shift by k ends k edges after accept
    always_comb begin
        src = load ? load_data : data;
        cnt_src = load ? load_cnt : cnt;
        step_right = load ? dir_right : right;
        data_next = step_right ? {1'b0, src[DATA_WIDTH-1:1]} : {src[DATA_WIDTH-2:0], 1'b0};
        done = (load || en) && cnt_src == SHAMT_WIDTH'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
            cnt <= '0;
            right <= 1'b0;
        end else if (load || en) begin
            data <= data_next;
            cnt <= cnt_src - SHAMT_WIDTH'(1);
            if (load) right <= dir_right;
        end
    end
endmodule

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute-stage ALU with single-cycle logic/arith ops and iterative SLL/SRL
// Ports: clk/reset; request in_valid/in_ready with alu_operation, operand_a, operand_b, shamt;
// response out_valid/out_ready with registered result, zero, overflow, illegal_op
module alu_iter_exec
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             alu_operation,
    input  logic [DATA_WIDTH-1:0]  operand_a,
    input  logic [DATA_WIDTH-1:0]  operand_b,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   overflow,
    output logic                   illegal_op
);
    state_e state, state_next;
    logic accept, start_shift, sh_done, alu_ovf, alu_ill;
    logic [DATA_WIDTH-1:0] sh_next, alu_res, sum, diff;

    assign accept = in_valid && state == S_IDLE;
    assign start_shift = accept && (alu_operation == OP_SLL || alu_operation == OP_SRL) && shamt != '0;

    alu_serial_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_WIDTH(SHAMT_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (start_shift),
        .dir_right(alu_operation == OP_SRL),
        .en       (state == S_SHIFT),
        .load_data(operand_b),
        .load_cnt (shamt),
        .data_next(sh_next),
        .done     (sh_done)
    );

    // single-cycle path; a zero-amount shift passes b straight through
    always_comb begin
        sum = operand_a + operand_b;
        diff = operand_a - operand_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_operation)
            OP_AND: alu_res = operand_a & operand_b;
            OP_OR:  alu_res = operand_a | operand_b;
            OP_NOR: alu_res = ~(operand_a | operand_b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = operand_a[DATA_WIDTH-1] == operand_b[DATA_WIDTH-1] && sum[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1];
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = operand_a[DATA_WIDTH-1] != operand_b[DATA_WIDTH-1] && diff[DATA_WIDTH-1] != operand_a[DATA_WIDTH-1];
            end
            OP_LUI: alu_res = {operand_b[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_SLL, OP_SRL: alu_res = operand_b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_next;
    end

    // a shift by one finishes on the accept edge itself and skips SHIFT
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = (start_shift && !sh_done) ? S_SHIFT : S_DONE;
            S_SHIFT: if (sh_done) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == S_IDLE;
        out_valid = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero <= 1'b0;
            overflow <= 1'b0;
            illegal_op <= 1'b0;
        end else if (accept && !start_shift) begin
            result <= alu_res;
            zero <= alu_res == '0;
            overflow <= alu_ovf;
            illegal_op <= alu_ill;
        end else if (sh_done) begin
            result <= sh_next;
            zero <= sh_next == '0;
            overflow <= 1'b0;
            illegal_op <= 1'b0;
        end
    end
endmodule
